gh_lane_sampler: RTL and testbench

// - Parametrised N-lane successor to the five-fret video player: samples one pixel per lane per frame

---
 rtl/gh_player_pkg.sv | 46 ++++
 rtl/gh_lane_detect.sv | 74 +++++++
 rtl/gh_lane_sampler.sv | 173 +++++++++++++++++
 tb/tb_gh_lane_sampler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gh_player_pkg.sv
// Purpose: shared types and colour-compare helpers for the lane sampler.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package gh_player_pkg;

    localparam int RGB_W = 24;
    localparam int CH_W  = 8;

    // Strum pulse generator states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT  = 2'd1,
        GAP  = 2'd2
    } strum_state_t;

    // Per-lane detector state.
    typedef struct packed {
        logic             state;
        logic [3:0]       dcnt;
        logic             got;
        logic [RGB_W-1:0] samp;
    } lane_state_t;

    function automatic logic [CH_W-1:0] ch_r(input logic [RGB_W-1:0] c);
        return c[23:16];
    endfunction

    function automatic logic [CH_W-1:0] ch_g(input logic [RGB_W-1:0] c);
        return c[15:8];
    endfunction

    function automatic logic [CH_W-1:0] ch_b(input logic [RGB_W-1:0] c);
        return c[7:0];
    endfunction

    // True when every channel of a is at or above the matching channel of b.
    function automatic logic ge_all(input logic [RGB_W-1:0] a, input logic [RGB_W-1:0] b);
        return (ch_r(a) >= ch_r(b)) && (ch_g(a) >= ch_g(b)) && (ch_b(a) >= ch_b(b));
    endfunction

    // True when every channel of a is at or below the matching channel of b.
    function automatic logic le_all(input logic [RGB_W-1:0] a, input logic [RGB_W-1:0] b);
        return (ch_r(a) <= ch_r(b)) && (ch_g(a) <= ch_g(b)) && (ch_b(a) <= ch_b(b));
    endfunction

endpackage

// File: rtl/gh_lane_detect.sv
// Purpose: one lane - capture the pixel at (pos_x,pos_y), colour hysteresis, frame debounce.
// Latency: capture registered on the pixel cycle; state commits on the vsync-edge cycle.
// Backpressure: none; follows the pixel stream unconditionally.
// Ports: clk/rst_n; commit = vsync edge; vde/rgb/x/y = pixel stream and raster position;
//        pos_x/pos_y/on_thr/off_thr = lane config; state_nxt = state after this cycle,
//        press = 0->1 transition committing this cycle, got = pixel captured this frame.
module gh_lane_detect
    import gh_player_pkg::*;
#(
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int DEBOUNCE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit,
    input  logic             vde,
    input  logic [RGB_W-1:0] rgb,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [X_W-1:0]   pos_x,
    input  logic [Y_W-1:0]   pos_y,
    input  logic [RGB_W-1:0] on_thr,
    input  logic [RGB_W-1:0] off_thr,
    output logic             state_nxt,
    output logic             press,
    output logic             got
);

    localparam logic [3:0] DEB4 = 4'(DEBOUNCE);

    lane_state_t ls, ls_nxt;
    logic        cand;
    logic        hit;

    assign hit = vde && (x == pos_x) && (y == pos_y);

    always_comb begin
        ls_nxt = ls;
        cand   = ls.state;
        press  = 1'b0;
        if (commit) begin
            // Commit wins over a coincident capture: the new frame starts empty.
            ls_nxt.got = 1'b0;
            if (ls.got) begin
                if (!ls.state) cand = ge_all(ls.samp, on_thr);
                else           cand = !le_all(ls.samp, off_thr);
                if (cand != ls.state) begin
                    if (ls.dcnt + 4'd1 == DEB4) begin
                        ls_nxt.state = cand;
                        ls_nxt.dcnt  = 4'd0;
                        press        = cand;
                    end else begin
                        ls_nxt.dcnt = ls.dcnt + 4'd1;
                    end
                end else begin
                    ls_nxt.dcnt = 4'd0;
                end
            end
        end else if (hit) begin
            ls_nxt.got  = 1'b1;
            ls_nxt.samp = rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ls <= '0;
        else        ls <= ls_nxt;
    end

    assign state_nxt = ls_nxt.state;
    assign got       = ls.got;

endmodule

// File: rtl/gh_lane_sampler.sv
// Purpose: N-lane fret/strum sampler from a video stream with a frame-delay buffer.
// Latency: outputs update one cycle after the vsync rising edge, delayed by delay_i frames.
// Backpressure: none; en_i only gates frets_o/strum_o, internal state always runs.
// Ports: CLK/RST_N; en_i output gate; vsync_i/hsync_i/vde_i/rgb_i pixel stream;
//        pos_x_i/pos_y_i/on_thr_i/off_thr_i packed per-lane config; delay_i frames of delay;
//        strum_time_i strum length in frames; frets_o/strum_o delayed result; valid_o lane captures.
module gh_lane_sampler
    import gh_player_pkg::*;
#(
    parameter  int N_LANES   = 5,
    parameter  int MAX_DELAY = 32,
    parameter  int X_W       = 11,
    parameter  int Y_W       = 10,
    parameter  int DEBOUNCE  = 1,
    localparam int DLY_W     = $clog2(MAX_DELAY)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     en_i,
    input  logic                     vsync_i,
    input  logic                     hsync_i,
    input  logic                     vde_i,
    input  logic [RGB_W-1:0]         rgb_i,
    input  logic [N_LANES*X_W-1:0]   pos_x_i,
    input  logic [N_LANES*Y_W-1:0]   pos_y_i,
    input  logic [N_LANES*RGB_W-1:0] on_thr_i,
    input  logic [N_LANES*RGB_W-1:0] off_thr_i,
    input  logic [DLY_W-1:0]         delay_i,
    input  logic [3:0]               strum_time_i,
    output logic [N_LANES-1:0]       frets_o,
    output logic                     strum_o,
    output logic [N_LANES-1:0]       valid_o
);

    // Sync edge detection and raster position.
    logic vsync_q, hsync_q, vde_q;
    logic vs_edge, hs_edge, vde_fall;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;

    assign vs_edge  = vsync_i & ~vsync_q;
    assign hs_edge  = hsync_i & ~hsync_q;
    assign vde_fall = vde_q & ~vde_i;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            vde_q   <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            vsync_q <= vsync_i;
            hsync_q <= hsync_i;
            vde_q   <= vde_i;
            if (hs_edge)    x_cnt <= '0;
            else if (vde_i) x_cnt <= x_cnt + X_W'(1);
            if (vs_edge)       y_cnt <= '0;
            else if (vde_fall) y_cnt <= y_cnt + Y_W'(1);
        end
    end

    // Lanes.
    logic [N_LANES-1:0] lane_nxt, lane_press, lane_got;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        gh_lane_detect #(
            .X_W      (X_W),
            .Y_W      (Y_W),
            .DEBOUNCE (DEBOUNCE)
        ) u_lane (
            .clk       (CLK),
            .rst_n     (RST_N),
            .commit    (vs_edge),
            .vde       (vde_i),
            .rgb       (rgb_i),
            .x         (x_cnt),
            .y         (y_cnt),
            .pos_x     (pos_x_i[k*X_W +: X_W]),
            .pos_y     (pos_y_i[k*Y_W +: Y_W]),
            .on_thr    (on_thr_i[k*RGB_W +: RGB_W]),
            .off_thr   (off_thr_i[k*RGB_W +: RGB_W]),
            .state_nxt (lane_nxt[k]),
            .press     (lane_press[k]),
            .got       (lane_got[k])
        );
    end

    // Strum FSM, advancing only on frame commits.
    strum_state_t st_q, st_d;
    logic [3:0]   scnt_q, scnt_d;
    logic [3:0]   strum_len;
    logic         any_press;

    assign strum_len = (strum_time_i == 4'd0) ? 4'd1 : strum_time_i;
    assign any_press = |lane_press;

    always_comb begin
        st_d   = st_q;
        scnt_d = scnt_q;
        if (vs_edge) begin
            case (st_q)
                IDLE: begin
                    if (any_press) begin
                        st_d   = ACT;
                        scnt_d = strum_len;
                    end
                end
                ACT: begin
                    // A fresh press re-triggers via a one-frame low gap.
                    if (any_press)            st_d   = GAP;
                    else if (scnt_q == 4'd1)  st_d   = IDLE;
                    else                      scnt_d = scnt_q - 4'd1;
                end
                GAP: begin
                    st_d   = ACT;
                    scnt_d = strum_len;
                end
                default: st_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q   <= IDLE;
            scnt_q <= 4'd0;
        end else begin
            st_q   <= st_d;
            scnt_q <= scnt_d;
        end
    end

    // Frame-indexed delay buffer. Word = {strum, frets} as committed this frame.
    logic [N_LANES:0] word;
    logic [N_LANES:0] rd_word;
    logic [N_LANES:0] dly_mem [MAX_DELAY];
    logic [DLY_W-1:0] wptr;

    assign word = {st_d == ACT, lane_nxt};
    // delay_i is never MAX_DELAY, so this read never aliases the slot being written.
    assign rd_word = dly_mem[wptr - delay_i];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < MAX_DELAY; i++) dly_mem[i] <= '0;
            wptr <= '0;
        end else if (vs_edge) begin
            dly_mem[wptr] <= word;
            wptr          <= wptr + DLY_W'(1);
        end
    end

    // Output registers, loaded once per frame.
    logic [N_LANES:0]   out_word;
    logic [N_LANES-1:0] valid_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_word <= '0;
            valid_q  <= '0;
        end else if (vs_edge) begin
            out_word <= (delay_i == '0) ? word : rd_word;
            valid_q  <= lane_got;
        end
    end

    // en_i masks fret/strum only; capture status stays visible.
    assign frets_o = en_i ? out_word[N_LANES-1:0] : '0;
    assign strum_o = en_i & out_word[N_LANES];
    assign valid_o = valid_q;

endmodule

// File: tb/tb_gh_lane_sampler.sv
// Purpose: self-checking bench for gh_lane_sampler on a small raster.
// Latency: checks outputs one cycle after each vsync rising edge.
// Backpressure: n/a.
module tb_gh_lane_sampler;

    localparam int N     = 5;
    localparam int MAXD  = 32;
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int DEB   = 3;
    localparam int W     = 12;
    localparam int LINES = 6;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            en_i, vsync_i, hsync_i, vde_i;
    logic [23:0]     rgb_i;
    logic [N*XW-1:0] pos_x_i;
    logic [N*YW-1:0] pos_y_i;
    logic [N*24-1:0] on_thr_i, off_thr_i;
    logic [4:0]      delay_i;
    logic [3:0]      strum_time_i;
    logic [N-1:0]    frets_o, valid_o;
    logic            strum_o;

    always #5 CLK = ~CLK;

    gh_lane_sampler #(
        .N_LANES   (N),
        .MAX_DELAY (MAXD),
        .X_W       (XW),
        .Y_W       (YW),
        .DEBOUNCE  (DEB)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .en_i         (en_i),
        .vsync_i      (vsync_i),
        .hsync_i      (hsync_i),
        .vde_i        (vde_i),
        .rgb_i        (rgb_i),
        .pos_x_i      (pos_x_i),
        .pos_y_i      (pos_y_i),
        .on_thr_i     (on_thr_i),
        .off_thr_i    (off_thr_i),
        .delay_i      (delay_i),
        .strum_time_i (strum_time_i),
        .frets_o      (frets_o),
        .strum_o      (strum_o),
        .valid_o      (valid_o)
    );

    int          n_chk, n_fail, fno;
    int          lx[N], ly[N];
    logic [23:0] on_t[N], off_t[N], col[N];
    bit          tgt[N];

    // Reference model state.
    bit           ms[N];
    int           mcnt[N];
    int           rem;
    bit           restart, prev_strum;
    logic [N:0]   hist[$];
    logic [N-1:0] exp_frets, exp_valid;
    logic         exp_strum;

    typedef struct {
        logic [23:0] c0;
        logic        fret0;
        logic        strum;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input logic [23:0] c);
        @(negedge CLK);
        vsync_i = vs;
        hsync_i = hs;
        vde_i   = de;
        rgb_i   = c;
    endtask

    task automatic apply_cfg();
        for (int k = 0; k < N; k++) begin
            pos_x_i[k*XW +: XW] = XW'(lx[k]);
            pos_y_i[k*YW +: YW] = YW'(ly[k]);
            on_thr_i[k*24 +: 24]  = on_t[k];
            off_thr_i[k*24 +: 24] = off_t[k];
        end
    endtask

    function automatic bit all_ge(input logic [23:0] a, input logic [23:0] b);
        for (int c = 0; c < 3; c++)
            if (((a >> (8*c)) & 24'hFF) < ((b >> (8*c)) & 24'hFF)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_le(input logic [23:0] a, input logic [23:0] b);
        for (int c = 0; c < 3; c++)
            if (((a >> (8*c)) & 24'hFF) > ((b >> (8*c)) & 24'hFF)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] pix(input int x, input int y);
        logic [23:0] p;
        p = 24'($urandom);
        for (int k = 0; k < N; k++)
            if (lx[k] == x && ly[k] == y) p = col[k];
        return p;
    endfunction

    function automatic logic [23:0] gen_col(input int k, input bit t);
        logic [23:0] c;
        int v;
        c = 24'd0;
        if ($urandom_range(0, 5) == 0) return 24'($urandom);
        for (int ch = 0; ch < 3; ch++) begin
            v = t ? int'($urandom_range(255, 128 + k)) : int'($urandom_range(32 + k, 0));
            c = c | (24'(v) << (8*ch));
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            ms[k]   = 1'b0;
            mcnt[k] = 0;
        end
        rem = 0;
        restart = 1'b0;
        prev_strum = 1'b0;
        hist.delete();
    endtask

    // One frame commit: lane hysteresis, strum pulse, history of committed words.
    task automatic model_commit();
        bit press, cand, s;
        int st, d;
        logic [N:0] w, outw;
        press = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_valid[k] = (lx[k] < W) && (ly[k] < LINES);
            if (exp_valid[k]) begin
                cand = ms[k] ? !all_le(col[k], off_t[k]) : all_ge(col[k], on_t[k]);
                if (cand != ms[k]) begin
                    mcnt[k]++;
                    if (mcnt[k] == DEB) begin
                        ms[k] = cand;
                        mcnt[k] = 0;
                        if (cand) press = 1'b1;
                    end
                end else begin
                    mcnt[k] = 0;
                end
            end
        end
        st = (strum_time_i == 4'd0) ? 1 : int'(strum_time_i);
        if (restart) begin
            restart = 1'b0; rem = st - 1; s = 1'b1;
        end else if (press && prev_strum) begin
            restart = 1'b1; s = 1'b0;
        end else if (press) begin
            rem = st - 1; s = 1'b1;
        end else if (rem > 0) begin
            rem--; s = 1'b1;
        end else begin
            s = 1'b0;
        end
        prev_strum = s;
        w[N] = s;
        for (int k = 0; k < N; k++) w[k] = ms[k];
        hist.push_back(w);
        d = int'(delay_i);
        if (d == 0)               outw = w;
        else if (hist.size() > d) outw = hist[hist.size() - 1 - d];
        else                      outw = '0;
        exp_frets = outw[N-1:0];
        exp_strum = outw[N];
    endtask

    task automatic check_outputs();
        check($sformatf("frets f%0d", fno), 32'(frets_o), en_i ? 32'(exp_frets) : 32'd0);
        check($sformatf("strum f%0d", fno), 32'(strum_o), en_i ? 32'(exp_strum) : 32'd0);
        check($sformatf("valid f%0d", fno), 32'(valid_o), 32'(exp_valid));
    endtask

    // Active lines followed by the vsync pulse; outputs checked one cycle after the edge.
    task automatic run_frame();
        for (int y = 0; y < LINES; y++) begin
            drive(1'b0, 1'b1, 1'b0, 24'd0);
            drive(1'b0, 1'b0, 1'b0, 24'd0);
            for (int x = 0; x < W; x++) drive(1'b0, 1'b0, 1'b1, pix(x, y));
            drive(1'b0, 1'b0, 1'b0, 24'd0);
            drive(1'b0, 1'b0, 1'b0, 24'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 24'($urandom));
        model_commit();
        drive(1'b1, 1'b0, 1'b0, 24'($urandom));
        fno++;
        check_outputs();
        drive(1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic set_cols(input logic [23:0] c);
        for (int k = 0; k < N; k++) col[k] = c;
    endtask

    int          dly_seq[10];
    logic [8:0]  strum_seq;
    logic [17:0] fret12_seq;

    initial begin
        n_chk = 0; n_fail = 0; fno = 0;
        RST_N = 1'b0; en_i = 1'b1;
        vsync_i = 1'b0; hsync_i = 1'b0; vde_i = 1'b0; rgb_i = 24'd0;
        delay_i = 5'd0; strum_time_i = 4'd2;
        for (int k = 0; k < N; k++) begin
            lx[k]    = 2 + 2*k;
            ly[k]    = k + 1;
            on_t[k]  = 24'(24'h808080 + 24'h010101 * 24'(k));
            off_t[k] = 24'(24'h202020 + 24'h010101 * 24'(k));
            tgt[k]   = 1'b0;
        end
        apply_cfg();
        set_cols(24'd0);
        model_reset();
        repeat (3) @(negedge CLK);
        check("reset frets", 32'(frets_o), 32'd0);
        check("reset strum", 32'(strum_o), 32'd0);
        check("reset valid", 32'(valid_o), 32'd0);
        RST_N = 1'b1;

        // Lane 0 hysteresis/debounce table (3-frame debounce, strum length 2).
        tbl = '{
            '{24'hFFFFFF, 1'b0, 1'b0}, '{24'hFFFFFF, 1'b0, 1'b0},
            '{24'h808080, 1'b1, 1'b1}, '{24'h7F8080, 1'b1, 1'b1},
            '{24'h000000, 1'b1, 1'b0}, '{24'h202020, 1'b1, 1'b0},
            '{24'h808080, 1'b1, 1'b0}, '{24'h000000, 1'b1, 1'b0},
            '{24'h212020, 1'b1, 1'b0}, '{24'h000000, 1'b1, 1'b0},
            '{24'h000000, 1'b1, 1'b0}, '{24'h000000, 1'b0, 1'b0},
            '{24'hFF0000, 1'b0, 1'b0}, '{24'h80807F, 1'b0, 1'b0}
        };
        for (int i = 0; i < 14; i++) begin
            col[0] = tbl[i].c0;
            run_frame();
            check($sformatf("tbl%0d fret0", i), 32'(frets_o[0]), 32'(tbl[i].fret0));
            check($sformatf("tbl%0d strum", i), 32'(strum_o), 32'(tbl[i].strum));
            check($sformatf("tbl%0d others", i), 32'(frets_o[N-1:1]), 32'd0);
            check($sformatf("tbl%0d valid", i), 32'(valid_o), 32'h1F);
        end

        // Re-trigger: lane1 presses, lane2 presses one frame later -> one low gap frame.
        strum_time_i = 4'd4;
        strum_seq  = 9'b011110100;                 // bit i = frame i+1, LSB first
        fret12_seq = 18'b11_11_11_11_11_11_01_00_00;
        for (int f = 0; f < 9; f++) begin
            col[1] = 24'hFFFFFF;
            col[2] = (f >= 1) ? 24'hFFFFFF : 24'h000000;
            run_frame();
            check($sformatf("gap f%0d strum", f), 32'(strum_o), 32'(strum_seq[f]));
            check($sformatf("gap f%0d fret12", f), 32'(frets_o[2:1]), 32'(fret12_seq[2*f +: 2]));
        end

        // Randomized run: delay changes (incl. wrap at 31), off-screen lane, en gating.
        dly_seq = '{0, 5, 31, 31, 3, 17, 0, 31, 5, 9};
        for (int f = 0; f < 150; f++) begin
            if (f % 15 == 0) begin
                delay_i      = 5'(dly_seq[f / 15]);
                strum_time_i = 4'($urandom_range(0, 15));
            end
            if (f == 60) begin ly[3] = 700; apply_cfg(); end
            if (f == 80) begin ly[3] = 4;   apply_cfg(); end
            en_i = !(f >= 90 && f < 100);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) tgt[k] = !tgt[k];
                col[k] = gen_col(k, tgt[k]);
            end
            run_frame();
            if (f >= 60 && f < 80) check($sformatf("offscreen f%0d", f), 32'(valid_o[3]), 32'd0);
            if (f >= 90 && f < 100) check($sformatf("en0 f%0d", f), 32'({strum_o, frets_o}), 32'd0);
        end

        // Reset mid-line with frets held down.
        en_i = 1'b1; delay_i = 5'd0;
        set_cols(24'hFFFFFF);
        repeat (4) run_frame();
        drive(1'b0, 1'b1, 1'b0, 24'd0);
        drive(1'b0, 1'b0, 1'b0, 24'd0);
        drive(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        drive(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        @(negedge CLK);
        RST_N = 1'b0; vde_i = 1'b0;
        #1;
        check("rst frets", 32'(frets_o), 32'd0);
        check("rst strum", 32'(strum_o), 32'd0);
        check("rst valid", 32'(valid_o), 32'd0);
        model_reset();
        delay_i = 5'd20;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 24'd0);
        for (int f = 0; f < 6; f++) begin
            run_frame();
            check($sformatf("post-rst buf f%0d", f), 32'({strum_o, frets_o}), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
